// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings and default timing constants
// used by the control, counter and display blocks.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        ALARM   = 2'd3
    } sw_state_e;

    localparam int unsigned TICK_DIV_DEF    = 1_000_000;
    localparam int unsigned BLINK_TICKS_DEF = 25;

endpackage

// File: rtl/stopwatch_ctrl_key_edge.sv
// Rising-edge detector for a debounced key level; a held key yields a single press.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    logic key_d;
    logic key_q;

    always_comb begin
        key_d = key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_d;
        end
    end

    assign press = key & ~key_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key command FSM, 10 ms count-tick prescaler and alarm LED blink.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned BLINK_TICKS = BLINK_TICKS_DEF
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       key_a,
    input  logic       key_b,
    input  logic       key_c,
    input  logic       cnt_max,
    output logic       cnt_inc,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       led_alarm
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic press_a, press_b, press_c;
    logic win_a, win_b, win_c;

    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d, presc_step;
    logic [BW-1:0] blink_q, blink_d;
    logic          inc_q, inc_d;
    logic          clr_q, clr_d;
    logic          led_q, led_d;
    logic          tick;

    key_edge u_edge_a (.clk(sys_clk), .rst_n(reset_n), .key(key_a), .press(press_a));
    key_edge u_edge_b (.clk(sys_clk), .rst_n(reset_n), .key(key_b), .press(press_b));
    key_edge u_edge_c (.clk(sys_clk), .rst_n(reset_n), .key(key_c), .press(press_c));

    // Only the highest-priority press (C > B > A) is acted on in a given cycle.
    assign win_c = press_c;
    assign win_b = press_b & ~press_c;
    assign win_a = press_a & ~press_b & ~press_c;

    assign tick       = (presc_q == PRESC_LAST);
    assign presc_step = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        blink_d = blink_q;
        inc_d   = 1'b0;
        clr_d   = 1'b0;
        led_d   = led_q;
        case (state_q)
            IDLE: begin
                if (win_a) begin
                    state_d = RUNNING;
                    presc_d = '0;
                end
            end
            RUNNING: begin
                if (win_c) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    presc_d = '0;
                end else if (cnt_max) begin
                    // Restart the prescaler so the first LED half period is a full one.
                    state_d = ALARM;
                    presc_d = '0;
                    blink_d = '0;
                    led_d   = 1'b1;
                end else begin
                    presc_d = presc_step;
                    inc_d   = tick;
                    if (win_b) state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (win_c) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    presc_d = '0;
                end else if (win_a) begin
                    state_d = RUNNING;
                end
            end
            ALARM: begin
                if (win_c) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    presc_d = '0;
                    blink_d = '0;
                    led_d   = 1'b0;
                end else begin
                    presc_d = presc_step;
                    if (tick) begin
                        if (blink_q == BLINK_LAST) begin
                            blink_d = '0;
                            led_d   = ~led_q;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            blink_q <= '0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            led_q   <= led_d;
        end
    end

    assign cnt_inc   = inc_q;
    assign cnt_clr   = clr_q;
    assign state     = state_q;
    assign led_alarm = led_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random key/cnt_max traffic against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int BT = 3;

    logic       sys_clk = 1'b0;
    logic       reset_n;
    logic       key_a, key_b, key_c, cnt_max;
    logic       cnt_inc, cnt_clr, led_alarm;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    // behavioural model: state number, running cycles since last tick, cycles spent in alarm
    int m_state, m_phase, m_acyc;
    bit m_inc, m_clr, m_led;
    bit pa, pb, pc;

    int n;
    bit ra, rb, rc, rm;

    stopwatch_ctrl #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .key_a    (key_a),
        .key_b    (key_b),
        .key_c    (key_c),
        .cnt_max  (cnt_max),
        .cnt_inc  (cnt_inc),
        .cnt_clr  (cnt_clr),
        .state    (state),
        .led_alarm(led_alarm)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_acyc = 0;
        m_inc = 0; m_clr = 0; m_led = 0;
        pa = 0; pb = 0; pc = 0;
    endtask

    task automatic model_edge();
        bit ea, eb, ec;
        int win;
        ea = key_a && !pa; eb = key_b && !pb; ec = key_c && !pc;
        pa = key_a; pb = key_b; pc = key_c;
        win = ec ? 3 : (eb ? 2 : (ea ? 1 : 0));
        m_inc = 0; m_clr = 0;
        case (m_state)
            0: if (win == 1) begin m_state = 1; m_phase = 0; end
            1: begin
                if (win == 3) begin
                    m_state = 0; m_clr = 1; m_phase = 0;
                end else if (cnt_max) begin
                    m_state = 3; m_acyc = 0; m_led = 1;
                end else begin
                    m_phase = m_phase + 1;
                    if (m_phase == TD) begin m_phase = 0; m_inc = 1; end
                    if (win == 2) m_state = 2;
                end
            end
            2: begin
                if (win == 3) begin m_state = 0; m_clr = 1; m_phase = 0; end
                else if (win == 1) m_state = 1;
            end
            default: begin
                if (win == 3) begin
                    m_state = 0; m_clr = 1; m_led = 0; m_phase = 0;
                end else begin
                    m_acyc = m_acyc + 1;
                    m_led = ((m_acyc / (TD * BT)) % 2) == 0;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("state", int'(state), m_state);
        check("cnt_inc", int'(cnt_inc), int'(m_inc));
        check("cnt_clr", int'(cnt_clr), int'(m_clr));
        check("led_alarm", int'(led_alarm), int'(m_led));
    endtask

    task automatic step(input bit a, input bit b, input bit c, input bit mx);
        key_a = a; key_b = b; key_c = c; cnt_max = mx;
        @(posedge sys_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int cnt, input bit a, input bit b, input bit c, input bit mx);
        for (int i = 0; i < cnt; i++) step(a, b, c, mx);
    endtask

    // cycles until cnt_inc is seen high; -1 if the bound expires
    task automatic wait_inc(input int bound, input bit a, output int cyc);
        cyc = -1;
        for (int i = 1; i <= bound; i++) begin
            step(a, 1'b0, 1'b0, 1'b0);
            if (cnt_inc === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_a = 0; key_b = 0; key_c = 0; cnt_max = 0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // C in IDLE is ignored, then a long quiet stretch
        steps(3, 0, 0, 1, 0);
        steps(200, 0, 0, 0, 0);

        // held A starts once; ticks every TD cycles
        step(1, 0, 0, 0);
        wait_inc(30, 1'b1, n);
        check("first_inc_gap", n, TD);
        wait_inc(30, 1'b1, n);
        check("second_inc_gap", n, TD);
        steps(30, 1, 0, 0, 0);

        // pause after 14 cycles, resume 100 later: next tick 6 cycles after resume
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        steps(13, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        steps(100, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        wait_inc(20, 1'b0, n);
        check("resume_inc_gap", n, 6);

        // clear from RUNNING, then from PAUSED
        step(0, 0, 1, 0);
        check("clr_running", int'(cnt_clr), 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        steps(7, 0, 0, 0, 0);
        step(0, 1, 0, 0);
        steps(5, 0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("clr_paused", int'(cnt_clr), 1);
        step(0, 0, 0, 0);

        // alarm: blink pattern, A/B ignored, C clears
        step(1, 0, 0, 0);
        steps(7, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("alarm_state", int'(state), 3);
        steps(40, 0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        steps(50, 0, 0, 0, 1);
        step(0, 0, 1, 1);
        check("alarm_clear_led", int'(led_alarm), 0);
        step(0, 0, 0, 0);

        // simultaneous A+B+C while RUNNING: C wins
        step(1, 0, 0, 0);
        steps(4, 0, 0, 0, 0);
        step(1, 1, 1, 0);
        check("abc_state", int'(state), 0);
        step(0, 0, 0, 0);

        // B with cnt_max: alarm wins, then async reset mid-alarm
        step(1, 0, 0, 0);
        steps(3, 0, 0, 0, 0);
        step(0, 1, 0, 1);
        check("b_vs_max", int'(state), 3);
        steps(17, 0, 0, 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        reset_n = 1'b1;
        steps(3, 0, 0, 0, 0);

        // random key and cnt_max traffic
        ra = 0; rb = 0; rc = 0; rm = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)  ra = ~ra;
            if ($urandom_range(0, 14) == 0) rb = ~rb;
            if ($urandom_range(0, 40) == 0) rc = ~rc;
            if (rm) rm = ($urandom_range(0, 9) != 0);
            else    rm = ($urandom_range(0, 80) == 0);
            step(ra, rb, rc, rm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM sequencing the stopwatch time-counter datapath. It turns debounced key levels A/B/C into start, pause, resume and clear commands, generates the 10 ms count-enable tick, and detects the max-time alarm condition. It drives the alarm LED blink. It sits between the key debouncers and the BCD time counter inside `top_stopwatch`.

## Interface
- `TICK_DIV`, 1_000_000: sys_clk cycles per count tick (10 ms at 100 MHz); must be ≥ 2.
- `BLINK_TICKS`, 25: ticks per alarm-LED half period (250 ms); must be ≥ 1.
- `sys_clk` input 1: single system clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `key_a` input 1: debounced level, active-high; start/resume.
- `key_b` input 1: debounced level, active-high; pause.
- `key_c` input 1: debounced level, active-high; clear.
- `cnt_max` input 1: from the counter; high while the count equals 1:59:99.
- `cnt_inc` output 1: one-cycle pulse; advance the counter by 1 centisecond.
- `cnt_clr` output 1: one-cycle pulse; synchronously zero the counter.
- `state` output 2: current FSM state encoding.
- `led_alarm` output 1: alarm LED, blinking in ALARM only.

## Operation
- Key presses are rising edges only. Each key is registered into `key_*_q`, and `press = key & ~key_q`. Held keys act once.
- Simultaneous presses: priority C > B > A. Only the winner is acted on.
- States: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, ALARM=2'd3.
- **IDLE**
  - A → RUNNING; prescaler cleared to 0.
  - B and C are ignored; `cnt_clr` is not pulsed.
- **RUNNING**
  - Prescaler counts 0..TICK_DIV-1 and wraps. `cnt_inc` pulses on the wrap.
  - B → PAUSED; prescaler holds its value.
  - C → IDLE; `cnt_clr` pulses, prescaler cleared.
  - `cnt_max`=1 → ALARM; `cnt_inc` is suppressed from that cycle on.
  - C beats `cnt_max`. `cnt_max` beats B.
- **PAUSED**
  - Prescaler frozen; `cnt_inc`=0.
  - A → RUNNING; prescaler resumes from its held value.
  - C → IDLE with `cnt_clr`.
  - B is ignored.
- **ALARM**
  - Prescaler keeps running and drives the blink counter. `led_alarm` toggles every BLINK_TICKS ticks, starting at 1 on entry.
  - A and B are ignored; `cnt_inc` is never asserted.
  - C → IDLE with `cnt_clr`; `led_alarm` goes to 0.
- Width rules: prescaler is $clog2(TICK_DIV) bits; blink counter is $clog2(BLINK_TICKS+1) bits. Both wrap exactly at terminal count, never modulo 2^n.

## Timing
- Reset (async assert, sync release): `state`=IDLE, `cnt_inc`=0, `cnt_clr`=0, `led_alarm`=0, prescaler=0, blink counter=0, `key_*_q`=0.
- All outputs are registered; there is no combinational path from input to output.
- A press sampled at edge k: `state`=RUNNING after edge k. The first `cnt_inc` is high after edge k+TICK_DIV, then every TICK_DIV cycles.
- C press sampled at edge k: `cnt_clr` is high after edge k for exactly one cycle, and `state`=IDLE after edge k.
- `cnt_max` is seen high at edge k in RUNNING: `state`=ALARM and `led_alarm`=1 after edge k. No `cnt_inc` occurs after edge k.
- `cnt_inc` and `cnt_clr` are never high in the same cycle.
- A pause/resume round trip loses no prescaler counts. Total RUNNING cycles between consecutive `cnt_inc` pulses equal TICK_DIV.
- Reset asserted mid-tick or mid-alarm returns all state and outputs to reset values immediately.

## Structure
- `stopwatch_pkg` holds the state encodings (IDLE/RUNNING/PAUSED/ALARM) and the default TICK_DIV/BLINK_TICKS constants. The counter and display blocks share it.
- One sub-module, `key_edge`: a registered rising-edge detector with async active-low reset, instanced three times.
- The FSM, prescaler and blink counter live in `stopwatch_ctrl`.

## Test plan
All scenarios use TICK_DIV=10 and BLINK_TICKS=3.
- Reset, then press C in IDLE → `state`=0, no `cnt_clr`, no `cnt_inc` for 200 cycles.
- Press A, hold for 50 cycles → exactly one transition to RUNNING. `cnt_inc` pulses at cycles +10, +20, … relative to the sampling edge.
- Press A, wait 14 cycles, press B, wait 100 cycles, press A → no `cnt_inc` while PAUSED. The next `cnt_inc` comes 6 cycles after resume.
- RUNNING, then press C → one-cycle `cnt_clr` and `state`=0. Repeat from PAUSED with the same result.
- RUNNING, raise `cnt_max` → `state`=3 next cycle, no further `cnt_inc`. `led_alarm` reads 1 for 30 cycles, 0 for 30, 1 for 30. Press A/B → no effect. Press C → `state`=0, `led_alarm`=0, `cnt_clr` pulse.
- Press A, B and C in the same cycle while RUNNING → C wins: IDLE plus `cnt_clr`. Press B while `cnt_max`=1 → ALARM. Drop `reset_n` mid-alarm → all outputs 0 asynchronously.
